// File: rtl/pipelined_mem_stage.sv
// Memory stage of an in-order pipeline: M register, load/store sequencing FSM and writeback mux.
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN faults misaligned half/word accesses instead of aligning them.
module pipelined_mem_stage #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_x,
  input  logic [31:0]       PC_x,
  input  logic [31:0]       alu_x,
  input  logic [31:0]       rs2_x,
  input  logic [31:0]       inst_x,
  output logic              stall_m,
  output logic              valid_m,
  output logic [31:0]       inst_m,
  output logic [31:0]       PC_m,
  output logic [31:0]       wb_m,
  output logic              fault_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [7:0] TIMEOUT  = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Undefined funct3 encodings fall back to a word access.
  function automatic size_t access_size(input logic is_store, input logic [2:0] f3);
    size_t sz;
    sz = SZ_W;
    if (is_store) begin
      if (f3 == 3'b000)      sz = SZ_B;
      else if (f3 == 3'b001) sz = SZ_H;
    end else begin
      if (f3 == 3'b000 || f3 == 3'b100)      sz = SZ_B;
      else if (f3 == 3'b001 || f3 == 3'b101) sz = SZ_H;
    end
    return sz;
  endfunction

  function automatic logic [1:0] lane_of(input size_t sz, input logic [1:0] a);
    logic [1:0] lane;
    case (sz)
      SZ_B:    lane = a;
      SZ_H:    lane = {a[1], 1'b0};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

  function automatic logic [3:0] byte_enable(input size_t sz, input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input size_t sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // funct3[2] selects zero extension for sub-word loads.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input size_t sz,
                                               input logic [1:0] lane, input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rd >> {lane, 3'b000};
    case (sz)
      SZ_B:    r = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    r = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rs2_q, rs2_d;

  logic        x_mem;
  logic        x_trap;
  logic        m_load;
  logic        m_store;
  logic        m_jump;
  size_t       m_size;
  logic [1:0]  m_lane;

  assign x_mem = valid_x && (inst_x[6:0] == OP_LOAD || inst_x[6:0] == OP_STORE);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  function automatic logic misaligned(input size_t sz, input logic [1:0] a);
    logic m;
    case (sz)
      SZ_H:    m = a[0];
      SZ_W:    m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  size_t x_size;
  assign x_size = access_size(inst_x[6:0] == OP_STORE, inst_x[14:12]);
  assign x_trap = x_mem && misaligned(x_size, alu_x[1:0]);
`else
  assign x_trap = 1'b0;
`endif

  assign m_load  = inst_q[6:0] == OP_LOAD;
  assign m_store = inst_q[6:0] == OP_STORE;
  assign m_jump  = inst_q[6:0] == OP_JAL || inst_q[6:0] == OP_JALR;
  assign m_size  = access_size(m_store, inst_q[14:12]);
  assign m_lane  = lane_of(m_size, alu_q[1:0]);
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    stall_m = 1'b0;
    case (state_q)
      S_REQ: begin
        stall_m = 1'b1;
        if (dmem_ack) begin
          state_d = S_DONE;
          rdata_d = dmem_rdata;
          fault_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            state_d = S_DONE;
            fault_d = 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept the incoming instruction this cycle.
        state_d = S_IDLE;
        fault_d = 1'b0;
        if (x_mem) begin
          if (x_trap) begin
            state_d = S_DONE;
            fault_d = 1'b1;
          end else begin
            state_d = S_REQ;
            cnt_d   = 8'd0;
          end
        end
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    rs2_d   = rs2_q;
    if (!stall_m) begin
      valid_d = valid_x;
      inst_d  = inst_x;
      pc_d    = PC_x;
      alu_d   = alu_x;
      rs2_d   = rs2_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      pc_q    <= 32'h0;
      alu_q   <= 32'h0;
      rs2_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      rs2_q   <= rs2_d;
    end
  end

  // Only non-memory instructions can sit in M while IDLE, so valid_q alone qualifies them.
  assign valid_m    = (state_q == S_DONE) || (state_q == S_IDLE && valid_q);
  assign fault_m    = (state_q == S_DONE) && fault_q;
  assign inst_m     = inst_q;
  assign PC_m       = pc_q;
  assign dmem_req   = state_q == S_REQ;
  assign dmem_we    = dmem_req && m_store;
  assign dmem_be    = dmem_we ? byte_enable(m_size, m_lane) : 4'b0000;
  assign dmem_addr  = alu_q[ADDR_W-1:0] & ~ADDR_W'(3);
  assign dmem_wdata = store_data(m_size, rs2_q);

  always_comb begin
    wb_m = alu_q;
    if (fault_m)     wb_m = 32'h0;
    else if (m_load) wb_m = load_extract(inst_q[14:12], m_size, m_lane, rdata_q);
    else if (m_jump) wb_m = pc_q + 32'd4;
  end

endmodule

// File: tb/tb_pipelined_mem_stage.sv
// Self-checking bench for pipelined_mem_stage: directed scenarios plus randomized traffic vs. a transaction model.
module tb_pipelined_mem_stage;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_x;
  logic [31:0] PC_x, alu_x, rs2_x, inst_x;
  logic        stall_m, valid_m, fault_m;
  logic [31:0] inst_m, PC_m, wb_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int total = 0;
  int bad   = 0;

  pipelined_mem_stage #(.ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_x(valid_x), .PC_x(PC_x), .alu_x(alu_x),
    .rs2_x(rs2_x), .inst_x(inst_x), .stall_m(stall_m), .valid_m(valid_m),
    .inst_m(inst_m), .PC_m(PC_m), .wb_m(wb_m), .fault_m(fault_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from opcode class and funct3.
  function automatic int msize(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int size, input int lane,
                                           input logic [31:0] rd);
    logic [31:0] mask, v;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v = (rd >> (8 * lane)) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && size < 4 && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  // Issue one instruction (entered and left at a negedge) and check its whole M-stage life.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2, input int ack_at, input logic [31:0] rdata);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        mem, st, trap, tmo, fault;
    int          size, a, lane, exp_cycles, n, w;
    logic [31:0] exp_wb, exp_be, exp_wd;
    op   = inst[6:0];
    f3   = inst[14:12];
    st   = op == 7'b0100011;
    mem  = st || op == 7'b0000011;
    size = msize(st, f3);
    a    = int'(alu[1:0]);
    lane = (a / size) * size;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    trap = mem && (a % size) != 0;
`else
    trap = 1'b0;
`endif
    tmo   = mem && !trap && !(ack_at >= 1 && ack_at <= TO);
    fault = trap || tmo;
    exp_cycles = (!mem || trap) ? 0 : tmo ? TO : ack_at;
    exp_be = st ? (((32'd1 << size) - 32'd1) << lane) : 32'd0;
    exp_wd = (size == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
             (size == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
    if (fault)                              exp_wb = 32'h0;
    else if (mem && !st)                    exp_wb = load_val(f3, size, lane, rdata);
    else if (op == 7'b1101111 || op == 7'b1100111) exp_wb = pc + 32'd4;
    else                                    exp_wb = alu;

    w = 0;
    while (stall_m !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("entry_stall_timeout", 32'(stall_m), 32'd0);

    valid_x = 1'b1; inst_x = inst; PC_x = pc; alu_x = alu; rs2_x = rs2;
    @(posedge clk);
    @(negedge clk);
    valid_x = 1'b0; inst_x = $urandom; PC_x = $urandom; alu_x = $urandom; rs2_x = $urandom;

    n = 0;
    while (stall_m === 1'b1 && n < 300) begin
      n++;
      chk("req", 32'(dmem_req), 32'd1);
      chk("addr", dmem_addr, alu & ~32'd3);
      chk("we", 32'(dmem_we), 32'(st));
      chk("be", 32'(dmem_be), exp_be);
      if (st) chk("wdata", dmem_wdata, exp_wd);
      chk("valid_in_req", 32'(valid_m), 32'd0);
      if (n == ack_at) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = $urandom;
    end
    chk("req_cycles", 32'(n), 32'(exp_cycles));
    chk("valid_m", 32'(valid_m), 32'd1);
    chk("fault_m", 32'(fault_m), 32'(fault));
    chk("wb_m", wb_m, exp_wb);
    chk("inst_m", inst_m, inst);
    chk("PC_m", PC_m, pc);
    chk("req_done", 32'(dmem_req), 32'd0);
    chk("stall_done", 32'(stall_m), 32'd0);
  endtask

  initial begin
    logic [31:0] ops [5];
    logic [31:0] inst;
    int          r, ack_at;
    ops[0] = 32'h13; ops[1] = 32'h33; ops[2] = 32'h6F; ops[3] = 32'h67; ops[4] = 32'h37;

    rst_n = 1'b0; valid_x = 1'b0; PC_x = '0; alu_x = '0; rs2_x = '0; inst_x = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_fault", 32'(fault_m), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wb", wb_m, 32'd0);
    chk("rst_inst", inst_m, 32'd0);
    chk("rst_pc", PC_m, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    dmem_ack = 1'b0;

    // Release and capture on the very first rising edge.
    rst_n = 1'b1;
    issue(32'h0000_006F, 32'h0000_1000, 32'h0, 32'h0, 0, 32'h0);
    issue(32'h0000_2003, 32'h0000_1004, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
    issue(32'h0000_0003, 32'h0000_1008, 32'h0000_0103, 32'h0, 2, 32'h8011_2233);
    issue(32'h0000_4003, 32'h0000_100C, 32'h0000_0103, 32'h0, 1, 32'h8011_2233);
    issue(32'h0000_1023, 32'h0000_1010, 32'h0000_0202, 32'h0000_ABCD, 4, 32'h0);
    issue(32'h0000_2003, 32'h0000_1014, 32'h0000_0040, 32'h0, 0, 32'h0);
    issue(32'h0000_0013, 32'h0000_1018, 32'h0000_0055, 32'h0, 0, 32'h0);
    issue(32'h0000_2003, 32'h0000_101C, 32'h0000_0101, 32'h0, 2, 32'h1234_5678);
    issue(32'h0000_2023, 32'h0000_1020, 32'h0000_0303, 32'h5566_7788, 1, 32'h0);
    issue(32'h0000_0067, 32'hFFFF_FFFC, 32'h0000_0999, 32'h0, 0, 32'h0);

    // Reset in the middle of a store request, then a stray ack.
    valid_x = 1'b1; inst_x = 32'h0000_2023; PC_x = 32'h2000; alu_x = 32'h400; rs2_x = 32'h1;
    @(posedge clk);
    @(negedge clk);
    valid_x = 1'b0;
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(dmem_req), 32'd0);
    chk("async_rst_stall", 32'(stall_m), 32'd0);
    chk("async_rst_be", 32'(dmem_be), 32'd0);
    chk("async_rst_valid", 32'(valid_m), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stray_ack_req", 32'(dmem_req), 32'd0);
    chk("stray_ack_valid", 32'(valid_m), 32'd0);
    chk("stray_ack_stall", 32'(stall_m), 32'd0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      inst = $urandom;
      if (r == 0)      inst[6:0] = 7'b0000011;
      else if (r == 1) inst[6:0] = 7'b0100011;
      else             inst[6:0] = ops[$urandom_range(0, 4)][6:0];
      r = $urandom_range(0, 9);
      ack_at = r;
      issue(inst, $urandom, $urandom, $urandom, ack_at, $urandom);
    end

    valid_x = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bubble_valid", 32'(valid_m), 32'd0);
    chk("bubble_stall", 32'(stall_m), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_mem_stage.md
PIPELINED_MEM_STAGE -- requirements
Module: pipelined_mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the data-memory address width; must be 2..32.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, meaning the max cycles to wait for dmem_ack, 1..255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 valid_x, PC_x, alu_x, rs2_x, inst_x  in  1/32/32/32/32  execute-stage instruction, PC, ALU result (address), store data, instruction word.
REQ-006 stall_m  out  1  high: execute stage must hold its outputs; capture is blocked.
REQ-007 valid_m, inst_m, PC_m, wb_m  out  1/32/32/32  M-stage result for writeback.
REQ-008 fault_m  out  1  qualifies valid_m; the access was suppressed or timed out.
REQ-009 dmem_req, dmem_we  out  1/1  memory request and write strobe.
REQ-010 dmem_addr, dmem_wdata, dmem_be  out  ADDR_W/32/4  word-aligned address, lane-shifted store data, byte enables.
REQ-011 dmem_ack, dmem_rdata  in  1/32  request completion and full-word read data, valid with ack.

Function
REQ-012 Opcodes: load 0000011, store 0100011, JAL 1101111, JALR 1100111; funct3 = inst[14:12].
REQ-013 M register (valid, inst, PC, alu, rs2) SHALL load from the *_x inputs on each edge where stall_m=0; a bubble (valid_x=0) loads valid=0.
REQ-014 FSM states: IDLE, REQ, DONE; reset to IDLE.
REQ-015 IDLE: non-memory valid instruction -> valid_m=1 the cycle after capture (latency 1); valid load/store -> REQ, stall_m=1.
REQ-016 REQ: dmem_req=1 with stable addr/we/be/wdata until dmem_ack; ack (including in the first REQ cycle) -> DONE, latching dmem_rdata; stall_m=1 throughout.
REQ-017 DONE: valid_m=1 for exactly one cycle, stall_m=0, next instruction captured at the end of the cycle; then IDLE, or REQ if the new instruction is memory.
REQ-018 A timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack; reaching ACK_TIMEOUT -> DONE with fault_m=1, wb_m=0, dmem_req dropped.
REQ-019 dmem_addr = alu[ADDR_W-1:2],2'b00; byte lane = alu[1:0].
REQ-020 Store byte enables: SB 0001<<lane; SH 0011<<lane; SW 1111; wdata replicates rs2 byte/half to every lane; dmem_be=0 for loads.
REQ-021 Load extract from latched data by lane: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-022 wb_m: load -> extracted data; JAL/JALR -> PC_m+4 (mod 2^32); store and all other opcodes -> alu.
REQ-023 Undefined load/store funct3 SHALL be treated as the word access.
REQ-024 fault_m=0 whenever no fault condition applies; valid_m=0 outputs need not be stable except wb_m.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, M valid=0, valid_m=0, fault_m=0, stall_m=0, dmem_req=0, dmem_we=0, dmem_be=0, all data outputs 0, counter 0.
REQ-026 Reset during REQ SHALL abandon the access; a later dmem_ack in IDLE SHALL be ignored.
REQ-027 Release SHALL be synchronous-safe: the first capture occurs on the first rising edge with rst_n high.

Configuration
REQ-028 Macro MEM_STAGE_MISALIGN_TRAP_EN defined: LH/LHU/SH with alu[0]=1, or LW/SW with alu[1:0]!=0, SHALL skip REQ, go IDLE->DONE, fault_m=1, wb_m=0, no dmem_req.
REQ-029 Macro undefined: misaligned half/word accesses SHALL proceed with alu[0] (half) or alu[1:0] (word) forced to 0; fault_m only from timeout.

Verification
REQ-030 LW alu=0x100, ack in the first REQ cycle, rdata=0xDEADBEEF -> dmem_addr=0x100, be=0000, valid_m two cycles after capture, wb_m=0xDEADBEEF.
REQ-031 LB then LBU, alu=0x103, rdata=0x80112233 -> wb_m=0xFFFFFF80 then 0x00000080.
REQ-032 SH alu=0x202, rs2=0x0000ABCD, ack after 3 cycles -> be=1100, wdata=0xABCDABCD, we=1, stall_m high 4 cycles.
REQ-033 JAL PC_x=0x1000 -> wb_m=0x1004, valid_m the next cycle, no dmem_req.
REQ-034 Load, ack never, ACK_TIMEOUT=15 -> fault_m=1, wb_m=0 after 15 REQ cycles; next instruction captured.
REQ-035 Macro on, LW alu=0x101 -> fault_m=1, no dmem_req; macro off -> dmem_addr=0x100, normal completion.
